// File: rtl/control_serializador.sv
// Sequencing controller for an external N-bit shift register: loads a word,
// then shifts it out one bit per consumer handshake.
`timescale 1ns/1ps

module control_serializador #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         lsb_first,
  input  logic         ser_ready,
  output logic         ser_data,
  output logic         ser_valid,
  output logic         done,
  output logic         reg_enb,
  output logic         reg_dir,
  output logic         reg_s_in,
  output logic [1:0]   reg_modo,
  output logic [N-1:0] reg_d,
  input  logic         reg_s_out
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    FIN   = 2'b11
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_word;
  logic            r_lsb;
  logic            r_in_ready;
  logic            r_ser_valid;
  logic            r_done;
  logic            r_load_enb;
  logic [1:0]      r_modo;

  // FSM with its outputs registered one state ahead of use
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_lsb       <= 1'b1;
      r_in_ready  <= 1'b1;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      r_load_enb  <= 1'b0;
      r_modo      <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word     <= in_data;
            r_lsb      <= lsb_first;
            r_state    <= LOAD;
            r_in_ready <= 1'b0;
            r_load_enb <= 1'b1;
            r_modo     <= 2'b10;
          end
        end
        LOAD: begin
          r_state     <= SHIFT;
          r_cnt       <= '0;
          r_load_enb  <= 1'b0;
          r_modo      <= 2'b00;
          r_ser_valid <= 1'b1;
        end
        SHIFT: begin
          // A stalled consumer freezes both the counter and the register
          if (ser_ready) begin
            if (r_cnt == LAST_BIT) begin
              r_state     <= FIN;
              r_cnt       <= '0;
              r_ser_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        FIN: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_ser_valid <= 1'b0;
          r_done      <= 1'b0;
          r_load_enb  <= 1'b0;
          r_modo      <= 2'b00;
        end
      endcase
    end
  end

  // Shift enable must follow ser_ready in the same cycle, so it is combinational
  assign reg_enb   = r_load_enb | (r_ser_valid & ser_ready);
  assign ser_data  = r_ser_valid & reg_s_out;
  assign ser_valid = r_ser_valid;
  assign in_ready  = r_in_ready;
  assign done      = r_done;
  assign reg_modo  = r_modo;
  assign reg_dir   = r_lsb;
  assign reg_d     = r_word;
  assign reg_s_in  = 1'b0;

endmodule

// File: tb/tb_control_serializador.sv
// Bench for control_serializador driving a behavioural 4-bit shift register,
// checked against a transaction-level model plus literal expectations.
`timescale 1ns/1ps

module tb_control_serializador;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_SHIFT = 2;
  localparam int P_FIN   = 3;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'b0000;
  logic       in_ready;
  logic       lsb_first = 1'b0;
  logic       ser_ready = 1'b1;
  logic       ser_data;
  logic       ser_valid;
  logic       done;
  logic       reg_enb;
  logic       reg_dir;
  logic       reg_s_in;
  logic [1:0] reg_modo;
  logic [3:0] reg_d;
  logic       reg_s_out;

  logic [3:0] sr_q;

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  logic cap[$];

  int         m_phase = P_IDLE;
  logic [3:0] m_word = 4'b0000;
  logic       m_lsb = 1'b1;
  logic       m_bits[$];

  always #5 clk = ~clk;

  control_serializador #(.N(4)) dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lsb_first(lsb_first), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_valid(ser_valid), .done(done),
    .reg_enb(reg_enb), .reg_dir(reg_dir), .reg_s_in(reg_s_in),
    .reg_modo(reg_modo), .reg_d(reg_d), .reg_s_out(reg_s_out)
  );

  // 4-bit universal shift register controlled by the DUT
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) sr_q <= 4'b0000;
    else if (reg_enb) begin
      case (reg_modo)
        2'b00:   sr_q <= reg_dir ? {reg_s_in, sr_q[3:1]} : {sr_q[2:0], reg_s_in};
        2'b01:   sr_q <= reg_dir ? {sr_q[0], sr_q[3:1]} : {sr_q[2:0], sr_q[3]};
        2'b10:   sr_q <= reg_d;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign reg_s_out = reg_dir ? sr_q[0] : sr_q[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: a word becomes a queue of bits that drains on handshakes
  initial forever begin
    @(posedge clk or negedge reset_L);
    if (!reset_L) begin
      m_phase = P_IDLE;
      m_word  = 4'b0000;
      m_lsb   = 1'b1;
      m_bits.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (in_valid) begin
          m_word = in_data;
          m_lsb  = lsb_first;
          m_bits.delete();
          for (int i = 0; i < 4; i++) m_bits.push_back(lsb_first ? in_data[i] : in_data[3-i]);
          m_phase = P_LOAD;
        end
        P_LOAD:  m_phase = P_SHIFT;
        P_SHIFT: if (ser_ready) begin
          void'(m_bits.pop_front());
          if (m_bits.size() == 0) m_phase = P_FIN;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, plus bit/done capture
  initial forever begin
    @(negedge clk);
    chk("in_ready", in_ready, m_phase == P_IDLE);
    chk("ser_valid", ser_valid, m_phase == P_SHIFT);
    chk("done", done, m_phase == P_FIN);
    chk("reg_enb", reg_enb, (m_phase == P_LOAD) || (m_phase == P_SHIFT && ser_ready));
    chk("reg_modo", reg_modo, (m_phase == P_LOAD) ? 32'd2 : 32'd0);
    chk("reg_dir", reg_dir, m_lsb);
    chk("reg_d", reg_d, m_word);
    chk("reg_s_in", reg_s_in, 32'd0);
    if (m_phase == P_SHIFT && m_bits.size() > 0) chk("ser_data", ser_data, m_bits[0]);
    if (ser_valid && ser_ready) cap.push_back(ser_data);
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] w, input logic lsb);
    cap.delete();
    in_valid  = 1'b1;
    in_data   = w;
    lsb_first = lsb;
    chk("accept_ready", in_ready, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({name, "_done_seen"}, done, 32'd1);
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp, input int n);
    logic a;
    chk({name, "_len"}, cap.size(), n);
    for (int i = 0; i < n; i++) begin
      a = (i < cap.size()) ? cap[i] : 1'bx;
      chk(name, a, exp[n-1-i]);
    end
  endtask

  initial begin
    int cnt;
    int d0;
    logic [3:0] q_snap;

    tick();
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_ser_valid", ser_valid, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_reg_enb", reg_enb, 32'd0);
    chk("rst_reg_modo", reg_modo, 32'd0);
    chk("rst_reg_dir", reg_dir, 32'd1);
    chk("rst_reg_d", reg_d, 32'd0);
    chk("rst_reg_s_in", reg_s_in, 32'd0);
    reset_L = 1'b1;
    tick();

    // LSB first 0110 -> 0,1,1,0 ; done in cycle 6 after acceptance
    d0 = n_done;
    send(4'b0110, 1'b1);
    wait_done("lsb", cnt);
    chk("lsb_done_cycle", 1 + cnt, 32'd6);
    tick();
    check_seq("lsb_seq", 8'b0000_0110, 4);
    chk("lsb_done_count", n_done - d0, 32'd1);

    // MSB first 1011 -> 1,0,1,1
    send(4'b1011, 1'b0);
    wait_done("msb", cnt);
    tick();
    check_seq("msb_seq", 8'b0000_1011, 4);

    // Backpressure: stall 3 cycles after bit 0
    send(4'b1001, 1'b1);
    tick();
    tick();
    ser_ready = 1'b0;
    q_snap = sr_q;
    chk("bp_q_after_bit0", q_snap, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_q_frozen", sr_q, q_snap);
      chk("bp_enb_low", reg_enb, 32'd0);
    end
    ser_ready = 1'b1;
    wait_done("bp", cnt);
    tick();
    check_seq("bp_seq", 8'b0000_1001, 4);

    // Busy: in_valid held, second word only after done
    d0 = n_done;
    cap.delete();
    in_valid = 1'b1; in_data = 4'b1111; lsb_first = 1'b1;
    tick();
    in_data = 4'b0000;
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      chk("busy_in_ready_low", in_ready, 32'd0);
      tick();
      cnt++;
    end
    chk("busy_fin_ready_low", in_ready, 32'd0);
    tick();
    chk("busy_idle_ready", in_ready, 32'd1);
    tick();
    in_valid = 1'b0;
    wait_done("busy2", cnt);
    tick();
    check_seq("busy_seq", 8'b1111_0000, 8);
    chk("busy_done_count", n_done - d0, 32'd2);

    // Reset in SHIFT after 2 bits of 1100
    d0 = n_done;
    send(4'b1100, 1'b1);
    tick();
    tick();
    tick();
    chk("rsh_bits_before", cap.size(), 32'd2);
    reset_L = 1'b0;
    #1;
    chk("rsh_in_ready", in_ready, 32'd1);
    chk("rsh_ser_valid", ser_valid, 32'd0);
    chk("rsh_done", done, 32'd0);
    chk("rsh_reg_enb", reg_enb, 32'd0);
    chk("rsh_reg_modo", reg_modo, 32'd0);
    chk("rsh_reg_dir", reg_dir, 32'd1);
    chk("rsh_reg_d", reg_d, 32'd0);
    tick();
    tick();
    reset_L = 1'b1;
    tick();
    tick();
    chk("rsh_no_done", n_done - d0, 32'd0);
    chk("rsh_waits_idle", in_ready, 32'd1);
    send(4'b0101, 1'b1);
    wait_done("rsh_next", cnt);
    tick();
    check_seq("rsh_next_seq", 8'b0000_1010, 4);

    // Idle: nothing moves for 10 cycles
    q_snap = sr_q;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_enb", reg_enb, 32'd0);
      chk("idle_q", sr_q, q_snap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_serializador.md
CONTROL_SERIALIZADOR -- requirements
Module: control_serializador

Interface
REQ-001 Parameter N, default 4, word width of the controlled shift register.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  requester presents a word on in_data.
REQ-005 in_data  input  N  word to transmit.
REQ-006 in_ready  output  1  controller accepts a word this cycle.
REQ-007 lsb_first  input  1  bit order, sampled with the word: 1 = LSB first, 0 = MSB first.
REQ-008 ser_ready  input  1  serial consumer accepts the current bit.
REQ-009 ser_data  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_data is valid.
REQ-011 done  output  1  one-cycle pulse after the last bit is accepted.
REQ-012 reg_enb  output  1  enable of the shift register.
REQ-013 reg_dir  output  1  register shift direction: 1 = toward bit 0, so s_out = q[0]; 0 = toward bit N-1, so s_out = q[N-1].
REQ-014 reg_s_in  output  1  serial fill bit into the register; always 0.
REQ-015 reg_modo  output  2  register mode: 00 = shift, 01 = rotate (unused), 10 = parallel load, 11 = unused.
REQ-016 reg_d  output  N  parallel-load data for the register.
REQ-017 reg_s_out  input  1  serial output of the register.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, SHIFT and FIN, encoded in 2 bits.
REQ-019 IDLE: in_ready=1 and reg_enb=0; on in_valid=1 the block SHALL latch in_data and lsb_first, then move to LOAD.
REQ-020 LOAD, exactly one cycle: reg_modo=10, reg_enb=1, reg_d=latched word, reg_dir=lsb_first; then move to SHIFT with the bit counter cleared to 0.
REQ-021 SHIFT: ser_valid=1, ser_data=reg_s_out (combinational), reg_modo=00, reg_dir=latched lsb_first.
REQ-022 SHIFT: reg_enb SHALL equal ser_ready, so the register holds while the consumer stalls.
REQ-023 Each SHIFT cycle with ser_ready=1 SHALL increment the counter (width clog2(N)+1).
REQ-024 When ser_ready=1 and counter==N-1, the block SHALL move to FIN.
REQ-025 FIN, exactly one cycle: done=1, reg_enb=0, ser_valid=0; then return to IDLE.
REQ-026 in_ready SHALL be 0 in LOAD, SHIFT and FIN; in_valid is ignored outside IDLE.
REQ-027 reg_d SHALL hold the latched word in all states; it is zero after reset.
REQ-028 Consecutive words: a new word is accepted no earlier than IDLE after FIN, giving a minimum word period of N+3 cycles.
REQ-029 A stall of any length in SHIFT SHALL neither lose nor repeat a bit.
REQ-030 ser_data is undefined when ser_valid=0.

Reset
REQ-031 reset_L=0 SHALL, without waiting for clk, force state IDLE, counter 0, latched word 0 and latched lsb_first 1.
REQ-032 During and after reset the outputs SHALL be: in_ready=1, ser_valid=0, done=0, reg_enb=0, reg_modo=00, reg_dir=1, reg_s_in=0, reg_d=0.
REQ-033 Reset asserted in LOAD or SHIFT SHALL abort the transfer, with no done pulse; after release the block waits in IDLE for a new in_valid.

Verification
REQ-034 Bench SHALL instantiate control_serializador together with the codebase's 4-bit shift register, N=4.
REQ-035 LSB-first: in_data=0110, lsb_first=1, ser_ready=1 -> ser_data sequence 0,1,1,0 on 4 consecutive ser_valid cycles; done pulses at cycle 6 after acceptance.
REQ-036 MSB-first: in_data=1011, lsb_first=0 -> ser_data sequence 1,0,1,1.
REQ-037 Backpressure: in_data=1001, LSB-first, ser_ready low 3 cycles after bit 0 -> register q frozen while stalled; sequence stays 1,0,0,1.
REQ-038 Busy: in_valid held high with 1111 then 0000 -> second word accepted only after done; outputs 1,1,1,1 then 0,0,0,0, with in_ready=0 between.
REQ-039 Reset mid-SHIFT after 2 bits of 1100 -> outputs return to REQ-032 values immediately; no done pulse; next word 0101 transmits correctly.
REQ-040 Idle check: in_valid=0 for 10 cycles -> reg_enb=0 and q unchanged.
